tl_apb_bridge: RTL
==================

# tl_apb_bridge

TileLink-UL slave-side bridge that consumes the single-beat, at-most-4-byte requests produced by the 32-bit fragmenter coupler and drives an APB-style peripheral bus. It handles one request at a time. Each accepted A-channel request becomes a two-phase APB transfer (SETUP then ACCESS), and the block returns exactly one D-channel response with the source echoed. A bus timeout stops an unresponsive peripheral from hanging the TileLink fabric.

## Interface
- TIMEOUT_CYCLES, 255: maximum ACCESS-phase cycles without pready before the transfer is aborted (≥1).
- clock  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high.
- auto_in_a_ready  output  1  A-channel ready.
- auto_in_a_valid  input  1  A-channel valid.
- auto_in_a_bits_opcode  input  3  0 = PutFullData, 1 = PutPartialData, 4 = Get.
- auto_in_a_bits_param  input  3  ignored.
- auto_in_a_bits_size  input  2  log2 bytes, 0..2.
- auto_in_a_bits_source  input  10  request ID.
- auto_in_a_bits_address  input  26  byte address.
- auto_in_a_bits_mask  input  4  byte lanes.
- auto_in_a_bits_data  input  32  write data.
- auto_in_a_bits_corrupt  input  1  poisoned write data.
- auto_in_d_ready  input  1  D-channel ready.
- auto_in_d_valid  output  1  D-channel valid.
- auto_in_d_bits_opcode  output  3  0 = AccessAck, 1 = AccessAckData.
- auto_in_d_bits_size  output  2  echo of the captured size.
- auto_in_d_bits_source  output  10  echo of the captured source.
- auto_in_d_bits_data  output  32  read data; 0 for writes.
- psel, penable, pwrite  output  1 each  APB controls.
- paddr  output  26  APB address.
- pwdata  output  32  APB write data.
- pstrb  output  4  APB write strobes.
- pready  input  1  APB ready.
- prdata  input  32  APB read data.
- timeout_err  output  1  one-cycle pulse when a transfer is aborted by timeout.

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - a_ready = 1.
  - On A fire, capture opcode, size, source, address, mask and data into registers.
  - Get, or a Put with corrupt = 0: go to SETUP.
  - Put with corrupt = 1, or any other opcode: go directly to RESP with AccessAck and data 0. No bus cycle is issued.
- SETUP: psel = 1, penable = 0; always advance to ACCESS after one cycle.
- ACCESS: psel = 1, penable = 1; the timeout counter increments each cycle.
  - pready = 1: latch prdata (Get only), go to RESP.
  - pready = 0 and counter = TIMEOUT_CYCLES−1: abort. Go to RESP with data 0 and pulse timeout_err.
- RESP:
  - d_valid = 1, holding opcode, size, source and data stable.
  - On d_ready, go to IDLE.
- APB field mapping:
  - pwrite = 1 for Puts.
  - paddr = captured address, verbatim.
  - pwdata = captured data.
  - pstrb = captured mask for Puts, 0000 for Get.
  - paddr, pwdata, pwrite and pstrb are held constant throughout SETUP and ACCESS.
- D opcode is 1 for Get (including timed-out Gets) and 0 otherwise.

## Timing
- Reset: state = IDLE; the counter and all outputs are 0, except a_ready = 1 (driven combinationally from IDLE).
- Minimum latency: A fire in cycle 0 → SETUP in cycle 1 → ACCESS in cycle 2 (pready = 1) → d_valid in cycle 3.
  - Best-case throughput is one request per 4 cycles when d_ready is held at 1.
- Each extra pready = 0 cycle adds one cycle of latency.
- The timeout counter is cleared on entry to SETUP. Its width is clog2(TIMEOUT_CYCLES+1).
  - pready arriving in the same cycle as the timeout threshold counts as success: no error, data is latched.
- a_ready is 0 in every state other than IDLE. A new request is not accepted in the cycle d fires; it is accepted in the following IDLE cycle.
- Outputs are registered or decoded from state only, with no combinational input-to-output path. Exception: none — a_ready depends on state only.
- Reset asserted mid-transfer:
  - Next cycle is IDLE with psel, penable and d_valid at 0.
  - The in-flight request is dropped with no response.
  - Any pending APB transfer is abandoned.

## Structure
- Shared package tl_pkg holds:
  - TL opcode constants: PUT_FULL = 0, PUT_PARTIAL = 1, GET = 4, ACK = 0, ACK_DATA = 1.
  - The bridge state enum.
- No sub-module; the counter and FSM live in one module.

## Test plan
- Get: Get at addr 0x0000104, source 0x3A5, with pready = 1 in the first ACCESS cycle and prdata = 0xCAFEF00D → d_valid at cycle 3 with opcode 1, data 0xCAFEF00D, source 0x3A5, size 2.
- PutPartialData: opcode 1, mask 0b0110, data 0x11223344, pready delayed 5 cycles → pwrite = 1, pstrb = 0110, pwdata stable for all 7 bus cycles; D returns AccessAck with data 0.
- Timeout: TIMEOUT_CYCLES = 4, Get with pready held at 0 → ACCESS lasts 4 cycles, then psel drops, timeout_err pulses once, and D returns AccessAckData with data 0.
- Backpressure: d_ready held at 0 for 10 cycles → D fields stay stable, a_ready = 0 and no new APB cycle starts; after d_ready is raised, a_ready = 1 one cycle later.
- Corrupt write: PutFullData with corrupt = 1 → psel never asserts and AccessAck arrives 1 cycle after A fire.
- Reset during ACCESS: reset pulsed while in ACCESS → next cycle psel = 0, d_valid = 0, a_ready = 1, and no response is ever issued for the dropped source.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared TileLink constants and the bridge state encoding for the TL-to-APB bridge.
package tl_pkg;

  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] GET         = 3'd4;
  localparam logic [2:0] ACK         = 3'd0;
  localparam logic [2:0] ACK_DATA    = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } bridge_state_e;

  function automatic logic is_put(input logic [2:0] op);
    return (op == PUT_FULL) || (op == PUT_PARTIAL);
  endfunction

endpackage

// File: rtl/tl_apb_bridge.sv
// TileLink-UL single-beat slave to APB bridge: one request at a time, SETUP/ACCESS
// bus phases, one D response per request, ACCESS phase bounded by a timeout.
//
// state  | meaning
// IDLE   | a_ready high, waiting for an A request
// SETUP  | psel high, penable low
// ACCESS | psel and penable high, waiting for pready or timeout
// RESP   | d_valid high until d_ready
module tl_apb_bridge
  import tl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  output logic        auto_in_a_ready,
  input  logic        auto_in_a_valid,
  input  logic [2:0]  auto_in_a_bits_opcode,
  input  logic [2:0]  auto_in_a_bits_param,
  input  logic [1:0]  auto_in_a_bits_size,
  input  logic [9:0]  auto_in_a_bits_source,
  input  logic [25:0] auto_in_a_bits_address,
  input  logic [3:0]  auto_in_a_bits_mask,
  input  logic [31:0] auto_in_a_bits_data,
  input  logic        auto_in_a_bits_corrupt,
  input  logic        auto_in_d_ready,
  output logic        auto_in_d_valid,
  output logic [2:0]  auto_in_d_bits_opcode,
  output logic [1:0]  auto_in_d_bits_size,
  output logic [9:0]  auto_in_d_bits_source,
  output logic [31:0] auto_in_d_bits_data,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [25:0] paddr,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic        pready,
  input  logic [31:0] prdata,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  bridge_state_e state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [1:0]    size_q, size_d;
  logic [9:0]    source_q, source_d;
  logic [25:0]   addr_q, addr_d;
  logic [3:0]    mask_q, mask_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tout_q, tout_d;

  logic unused_param;
  assign unused_param = ^auto_in_a_bits_param;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    size_d   = size_q;
    source_d = source_q;
    addr_d   = addr_q;
    mask_d   = mask_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    tout_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (auto_in_a_valid) begin
          op_d     = auto_in_a_bits_opcode;
          size_d   = auto_in_a_bits_size;
          source_d = auto_in_a_bits_source;
          addr_d   = auto_in_a_bits_address;
          mask_d   = auto_in_a_bits_mask;
          wdata_d  = auto_in_a_bits_data;
          rdata_d  = '0;
          // Poisoned writes and unsupported opcodes are acked without touching the bus.
          if ((auto_in_a_bits_opcode == GET) ||
              (is_put(auto_in_a_bits_opcode) && !auto_in_a_bits_corrupt)) begin
            state_d = ST_SETUP;
            cnt_d   = '0;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        if (pready) begin
          if (op_q == GET) rdata_d = prdata;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          tout_d  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (auto_in_d_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      size_q   <= '0;
      source_q <= '0;
      addr_q   <= '0;
      mask_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      size_q   <= size_d;
      source_q <= source_d;
      addr_q   <= addr_d;
      mask_q   <= mask_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      tout_q   <= tout_d;
    end
  end

  logic bus_active;
  assign bus_active = (state_q == ST_SETUP) || (state_q == ST_ACCESS);

  assign auto_in_a_ready       = (state_q == ST_IDLE);
  assign auto_in_d_valid       = (state_q == ST_RESP);
  assign auto_in_d_bits_opcode = (op_q == GET) ? ACK_DATA : ACK;
  assign auto_in_d_bits_size   = size_q;
  assign auto_in_d_bits_source = source_q;
  assign auto_in_d_bits_data   = rdata_q;
  assign psel                  = bus_active;
  assign penable               = (state_q == ST_ACCESS);
  // Gated so the bus reads as a quiet read while idle and out of reset.
  assign pwrite                = bus_active && is_put(op_q);
  assign paddr                 = addr_q;
  assign pwdata                = wdata_q;
  assign pstrb                 = is_put(op_q) ? mask_q : 4'b0000;
  assign timeout_err           = tout_q;

endmodule
